axi_lite_sram_slave: RTL and testbench

AXI_LITE_SRAM_SLAVE -- requirements
Module: axi_lite_sram_slave

---
 rtl/axi_pkg.sv | 26 ++
 rtl/axi_sram_mem.sv | 37 +++
 rtl/axi_lite_sram_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite slave definitions: response codes, FSM state types and LFSR helpers
// used by the optional random response-delay build (AXI_SLAVE_RAND_DELAY_EN).
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_RESP    = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Fibonacci form of x^8 + x^6 + x^5 + x^4 + 1
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Byte-lane SRAM: one byte-strobed write port, one registered read port (read-first).
// Contents are never reset.
module axi_sram_mem #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int IDXW   = $clog2(DEPTH)
) (
  input  logic                ACLK,
  input  logic                we,
  input  logic [IDXW-1:0]     waddr,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] wstrb,
  input  logic                re,
  input  logic [IDXW-1:0]     raddr,
  output logic [DWIDTH-1:0]   rdata
);

  localparam int NB = DWIDTH / 8;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] ram_reg [DEPTH];
    logic [7:0] rd_byte_reg;

    // Read and write in one block so a same-cycle hit returns the old byte
    always_ff @(posedge ACLK) begin
      if (we && wstrb[gi]) begin
        ram_reg[waddr] <= wdata[gi*8 +: 8];
      end
      if (re) begin
        rd_byte_reg <= ram_reg[raddr];
      end
    end

    assign rdata[gi*8 +: 8] = rd_byte_reg;
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a DEPTH x DWIDTH SRAM with independent read and write FSMs.
// Define AXI_SLAVE_RAND_DELAY_EN to add an LFSR-driven 0-3 cycle delay to BVALID/RVALID.
module axi_lite_sram_slave
  import axi_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                ACLK,
  input  logic                ARESTn,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [AWIDTH-1:0]   AWADDR,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DWIDTH-1:0]   WDATA,
  input  logic [DWIDTH/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [AWIDTH-1:0]   ARADDR,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DWIDTH-1:0]   RDATA,
  output logic [1:0]          RRESP
);

  localparam int NB   = DWIDTH / 8;
  localparam int OFFS = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);

  function automatic logic out_of_range(input logic [AWIDTH-1:0] a);
    return (a >> OFFS) >= AWIDTH'(DEPTH);
  endfunction

  wr_state_t         wstate_reg;
  logic              awready_reg;
  logic              wready_reg;
  logic              aw_held_reg;
  logic              w_held_reg;
  logic [AWIDTH-1:0] awaddr_reg;
  logic [DWIDTH-1:0] wdata_reg;
  logic [NB-1:0]     wstrb_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;

  rd_state_t         rstate_reg;
  logic              arready_reg;
  logic              rvalid_reg;
  logic [1:0]        rresp_reg;

  logic [DWIDTH-1:0] mem_rdata;

`ifdef AXI_SLAVE_RAND_DELAY_EN
  logic [7:0] lfsr_reg;
  logic [1:0] bdly_reg;
  logic [1:0] rdly_reg;

  always_ff @(posedge ACLK or negedge ARESTn) begin
    if (!ARESTn) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end
`endif

  // Write commit happens in the cycle both halves are available, either latched or arriving now
  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [NB-1:0]     wr_strb;
  logic              wr_oor;
  logic              mem_we;

  assign aw_hs   = AWVALID && awready_reg;
  assign w_hs    = WVALID && wready_reg;
  assign wr_addr = aw_held_reg ? awaddr_reg : AWADDR;
  assign wr_data = w_held_reg ? wdata_reg : WDATA;
  assign wr_strb = w_held_reg ? wstrb_reg : WSTRB;
  assign commit  = (wstate_reg != W_RESP) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
  assign wr_oor  = out_of_range(wr_addr);
  assign mem_we  = commit && !wr_oor;

  always_ff @(posedge ACLK or negedge ARESTn) begin
    if (!ARESTn) begin
      wstate_reg  <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
`ifdef AXI_SLAVE_RAND_DELAY_EN
      bdly_reg    <= 2'd0;
`endif
    end else begin
      case (wstate_reg)
        W_RESP: begin
`ifdef AXI_SLAVE_RAND_DELAY_EN
          if (!bvalid_reg) begin
            if (bdly_reg <= 2'd1) begin
              bvalid_reg <= 1'b1;
            end
            bdly_reg <= bdly_reg - 2'd1;
          end
`endif
          if (bvalid_reg && BREADY) begin
            bvalid_reg  <= 1'b0;
            wstate_reg  <= W_IDLE;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        default: begin
          if (commit) begin
            wstate_reg  <= W_RESP;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bresp_reg   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_SLAVE_RAND_DELAY_EN
            bdly_reg    <= lfsr_reg[1:0];
            bvalid_reg  <= (lfsr_reg[1:0] == 2'd0);
`else
            bvalid_reg  <= 1'b1;
`endif
          end else begin
            if (aw_hs) begin
              aw_held_reg <= 1'b1;
              awaddr_reg  <= AWADDR;
            end
            if (w_hs) begin
              w_held_reg <= 1'b1;
              wdata_reg  <= WDATA;
              wstrb_reg  <= WSTRB;
            end
            awready_reg <= !(aw_held_reg || aw_hs);
            wready_reg  <= !(w_held_reg || w_hs);
            wstate_reg  <= (aw_held_reg || aw_hs || w_held_reg || w_hs) ? W_COLLECT : W_IDLE;
          end
        end
      endcase
    end
  end

  logic ar_hs;
  logic rd_oor;
  logic mem_re;

  assign ar_hs  = ARVALID && arready_reg;
  assign rd_oor = out_of_range(ARADDR);
  assign mem_re = ar_hs && !rd_oor;

  always_ff @(posedge ACLK or negedge ARESTn) begin
    if (!ARESTn) begin
      rstate_reg  <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
`ifdef AXI_SLAVE_RAND_DELAY_EN
      rdly_reg    <= 2'd0;
`endif
    end else begin
      case (rstate_reg)
        R_DATA: begin
`ifdef AXI_SLAVE_RAND_DELAY_EN
          if (!rvalid_reg) begin
            if (rdly_reg <= 2'd1) begin
              rvalid_reg <= 1'b1;
            end
            rdly_reg <= rdly_reg - 2'd1;
          end
`endif
          if (rvalid_reg && RREADY) begin
            rvalid_reg  <= 1'b0;
            rstate_reg  <= R_IDLE;
            arready_reg <= 1'b1;
          end
        end
        default: begin
          if (ar_hs) begin
            rstate_reg  <= R_DATA;
            arready_reg <= 1'b0;
            rresp_reg   <= rd_oor ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_SLAVE_RAND_DELAY_EN
            rdly_reg    <= lfsr_reg[1:0];
            rvalid_reg  <= (lfsr_reg[1:0] == 2'd0);
`else
            rvalid_reg  <= 1'b1;
`endif
          end else begin
            arready_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  axi_sram_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .IDXW   (IDXW)
  ) u_mem (
    .ACLK  (ACLK),
    .we    (mem_we),
    .waddr (wr_addr[OFFS +: IDXW]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .re    (mem_re),
    .raddr (ARADDR[OFFS +: IDXW]),
    .rdata (mem_rdata)
  );

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;
  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RRESP   = rresp_reg;
  // The read register is not reset, so data is masked whenever no OKAY response is presented
  assign RDATA   = (rvalid_reg && rresp_reg == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed plus randomized bench for axi_lite_sram_slave against a word-array reference model.
module tb_axi_lite_sram_slave;

  logic        ACLK;
  logic        ARESTn;
  logic        AWVALID;
  logic        AWREADY;
  logic [63:0] AWADDR;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] ARADDR;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  int vectors;
  int miscompares;
  logic [31:0] model [1024];

  axi_lite_sram_slave #(
    .DWIDTH (32),
    .AWIDTH (64),
    .DEPTH  (1024)
  ) dut (
    .ACLK    (ACLK),
    .ARESTn  (ARESTn),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .ARADDR  (ARADDR),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_oor(input logic [63:0] a);
    return (a >> 2) >= 64'd1024;
  endfunction

  // lead > 0: W precedes AW by lead cycles; lead < 0: AW precedes W; 0: same cycle
  task automatic do_write(input logic [63:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead);
    logic [1:0] exp_resp;
    int idx;
    exp_resp = is_oor(addr) ? 2'b10 : 2'b00;
    idx = int'(addr[11:2]);
    check("awready_pre", AWREADY, 1);
    check("wready_pre", WREADY, 1);
    if (lead > 0) begin
      WVALID = 1'b1; WDATA = data; WSTRB = strb;
      tick();
      WVALID = 1'b0;
      for (int i = 1; i < lead; i++) tick();
      check("wready_held", WREADY, 0);
      check("bvalid_early", BVALID, 0);
      AWVALID = 1'b1; AWADDR = addr;
      tick();
      AWVALID = 1'b0;
    end else if (lead < 0) begin
      AWVALID = 1'b1; AWADDR = addr;
      tick();
      AWVALID = 1'b0;
      for (int i = 1; i < -lead; i++) tick();
      check("awready_held", AWREADY, 0);
      check("bvalid_early", BVALID, 0);
      WVALID = 1'b1; WDATA = data; WSTRB = strb;
      tick();
      WVALID = 1'b0;
    end else begin
      AWVALID = 1'b1; AWADDR = addr;
      WVALID = 1'b1; WDATA = data; WSTRB = strb;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    check("bvalid_latency", BVALID, 1);
    for (int i = 0; i < 16 && BVALID !== 1'b1; i++) tick();
    check("bresp", BRESP, exp_resp);
    if (!is_oor(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    $display("WR addr=%h data=%h strb=%b lead=%0d bresp=%0d", addr, data, strb, lead, BRESP);
    if (BREADY) begin
      tick();
      check("bvalid_clear", BVALID, 0);
      check("awready_post", AWREADY, 1);
      check("wready_post", WREADY, 1);
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input int hold, output logic [31:0] got);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = is_oor(addr) ? 32'h0 : model[int'(addr[11:2])];
    exp_resp = is_oor(addr) ? 2'b10 : 2'b00;
    check("arready_pre", ARREADY, 1);
    RREADY = (hold == 0);
    ARVALID = 1'b1; ARADDR = addr;
    tick();
    ARVALID = 1'b0;
    check("rvalid_latency", RVALID, 1);
    for (int i = 0; i < 16 && RVALID !== 1'b1; i++) tick();
    check("rdata", RDATA, exp_data);
    check("rresp", RRESP, exp_resp);
    got = RDATA;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rvalid_hold", RVALID, 1);
      check("rdata_hold", RDATA, exp_data);
      check("arready_hold", ARREADY, 0);
    end
    $display("RD addr=%h rdata=%h rresp=%0d hold=%0d", addr, RDATA, RRESP, hold);
    RREADY = 1'b1;
    tick();
    check("rvalid_clear", RVALID, 0);
    check("arready_post", ARREADY, 1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] old_word;
    logic [63:0] a;
    int kind;

    vectors = 0; miscompares = 0;
    ARESTn = 1'b0;
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0;
    BREADY = 1'b1; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rresp", RRESP, 0);
    check("rst_rdata", RDATA, 0);
    #2 ARESTn = 1'b1;
    tick();
    check("rel_awready", AWREADY, 1);
    check("rel_wready", WREADY, 1);
    check("rel_arready", ARREADY, 1);

    for (int i = 0; i < 32; i++) do_write(64'(i * 4), $urandom, 4'hF, 0);

    // Same-cycle AW/W, then read back
    do_write(64'h10, 32'hDEADBEEF, 4'hF, 0);
    do_read(64'h10, 0, got);
    check("deadbeef", got, 32'hDEADBEEF);

    // W three cycles ahead of AW, only byte 0 strobed
    do_write(64'h10, 32'h000000AA, 4'b0001, 3);
    do_read(64'h10, 0, got);
    check("deadbeaa", got, 32'hDEADBEAA);

    // Out-of-range read and write; index 1024 must not alias index 0
    do_read(64'h1000, 0, got);
    do_write(64'h1000, 32'h12345678, 4'hF, 0);
    do_read(64'h0, 0, got);

    // Misaligned low bits ignored
    do_write(64'h1B, 32'hCAFEF00D, 4'hF, -2);
    do_read(64'h18, 0, got);

    // Read data held while RREADY low
    do_read(64'h10, 5, got);

    // Read capture and write commit to the same word in one cycle
    old_word = model[5];
    AWVALID = 1'b1; AWADDR = 64'h14; WVALID = 1'b1; WDATA = 32'h5A5A1234; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 64'h14;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("rw_rvalid", RVALID, 1);
    check("rw_rdata_old", RDATA, old_word);
    check("rw_bvalid", BVALID, 1);
    check("rw_bresp", BRESP, 0);
    model[5] = 32'h5A5A1234;
    $display("RW addr=%h rdata=%h bresp=%0d", 64'h14, RDATA, BRESP);
    tick();
    do_read(64'h14, 0, got);

    // Reset while BVALID is high
    BREADY = 1'b0;
    do_write(64'h20, 32'h0BADC0DE, 4'hF, 0);
    tick();
    check("bvalid_stable", BVALID, 1);
    #2 ARESTn = 1'b0;
    #1;
    check("arst_bvalid", BVALID, 0);
    check("arst_awready", AWREADY, 0);
    check("arst_arready", ARREADY, 0);
    #2 ARESTn = 1'b1;
    BREADY = 1'b1;
    tick();
    check("arel_awready", AWREADY, 1);
    check("arel_wready", WREADY, 1);
    check("arel_arready", ARREADY, 1);
    check("arel_bvalid", BVALID, 0);
    $display("RST during BVALID");
    do_read(64'h20, 0, got);

    // Reset with write data latched but no address: the write is lost
    WVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF;
    tick();
    WVALID = 1'b0;
    check("pend_wready", WREADY, 0);
    #2 ARESTn = 1'b0;
    #1 ARESTn = 1'b1;
    tick();
    check("pend_wready_rel", WREADY, 1);
    $display("RST with pending W");
    do_read(64'h24, 0, got);

    // Randomized mix
    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) a = (64'($urandom_range(1024, 5000)) << 2) | 64'($urandom_range(0, 3));
      else a = (64'($urandom_range(0, 31)) << 2) | 64'($urandom_range(0, 3));
      if (kind < 5) do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3);
      else do_read(a, int'($urandom_range(0, 3)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
